// File: rtl/jtkunio_romarb.sv
// Graphics ROM arbiter: scroll has fixed priority, object/char share round-robin,
// and each requester keeps a one-entry tag cache so repeated addresses skip the ROM.
module jtkunio_romarb #(
  parameter int AW   = 17,
  parameter int DW   = 32,
  parameter int TOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] scr_addr,
  input  logic          scr_cs,
  output logic [DW-1:0] scr_data,
  output logic          scr_ok,
  input  logic [AW-1:0] obj_addr,
  input  logic          obj_cs,
  output logic [DW-1:0] obj_data,
  output logic          obj_ok,
  input  logic [AW-1:0] chr_addr,
  input  logic          chr_cs,
  output logic [DW-1:0] chr_data,
  output logic          chr_ok,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok,
  output logic [7:0]    tout_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;
  typedef enum logic [1:0] {SCR = 2'd0, OBJ = 2'd1, CHR = 2'd2} req_t;

  localparam logic [7:0] TLIM = 8'(TOUT);

  state_t        state, state_nx;
  req_t          owner, rr, win;
  logic [7:0]    wcnt;
  logic [AW-1:0] req_addr [3];
  logic [AW-1:0] tag      [3];
  logic [DW-1:0] data     [3];
  logic [2:0]    req_cs, hit, pend, valid;
  logic [AW-1:0] own_addr;
  logic          own_cs, own_match, fill, abort, tmo, any_pend;

  assign req_addr[0] = scr_addr;
  assign req_addr[1] = obj_addr;
  assign req_addr[2] = chr_addr;
  assign req_cs      = {chr_cs, obj_cs, scr_cs};

  for (genvar i = 0; i < 3; i++) begin : g_req
    assign hit[i] = req_cs[i] & valid[i] & (req_addr[i] == tag[i]);
  end

  assign pend     = req_cs & ~hit;
  assign any_pend = |pend;

  assign scr_ok   = hit[0];
  assign obj_ok   = hit[1];
  assign chr_ok   = hit[2];
  assign scr_data = data[0];
  assign obj_data = data[1];
  assign chr_data = data[2];

  always_comb begin
    win = CHR;
    if (pend[0])                win = SCR;
    else if (pend[1] & pend[2]) win = rr;
    else if (pend[1])           win = OBJ;
  end

  always_comb begin
    own_cs   = scr_cs;
    own_addr = scr_addr;
    case (owner)
      OBJ:     begin own_cs = obj_cs; own_addr = obj_addr; end
      CHR:     begin own_cs = chr_cs; own_addr = chr_addr; end
      default: ;
    endcase
  end

  // First WAIT cycle ignores rom_ok: it may still be asserted for the previous access
  assign own_match = own_cs && (own_addr == rom_addr);
  assign fill      = (state == WAIT) && rom_ok && (wcnt != '0) && own_match;
  assign tmo       = (state == WAIT) && !fill && (wcnt == TLIM);
  assign abort     = (state == WAIT) && !fill && (!own_match || (wcnt == TLIM));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_pend) state_nx = WAIT;
      WAIT:    if (fill || abort) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      owner    <= SCR;
      rr       <= OBJ;
      wcnt     <= '0;
      tout_cnt <= '0;
      valid    <= '0;
      tag      <= '{default: '0};
      data     <= '{default: '0};
    end else begin
      case (state)
        IDLE: if (any_pend) begin
          rom_addr <= req_addr[win];
          rom_cs   <= 1'b1;
          owner    <= win;
          wcnt     <= '0;
        end
        WAIT: begin
          wcnt <= wcnt + 8'd1;
          if (fill) begin
            data[owner]  <= rom_data;
            tag[owner]   <= rom_addr;
            valid[owner] <= 1'b1;
          end
          if (fill || abort) begin
            rom_cs <= 1'b0;
            if (owner != SCR) rr <= (owner == OBJ) ? CHR : OBJ;
          end
          if (tmo && (tout_cnt != '1)) tout_cnt <= tout_cnt + 8'd1;
        end
        default: rom_cs <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkunio_romarb.sv
// Scoreboard bench for jtkunio_romarb: a scripted ROM responder pushes the data it
// returns, and the owner's ok/data are popped and compared once the fill lands.
module tb_jtkunio_romarb;
  localparam int AW = 17;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] scr_addr, obj_addr, chr_addr, rom_addr;
  logic          scr_cs, obj_cs, chr_cs, rom_cs, rom_ok;
  logic [DW-1:0] scr_data, obj_data, chr_data, rom_data;
  logic          scr_ok, obj_ok, chr_ok;
  logic [7:0]    tout_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct { int who; logic [DW-1:0] data; } exp_t;
  exp_t sbq[$];

  jtkunio_romarb #(.AW(AW), .DW(DW), .TOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_data(obj_data), .obj_ok(obj_ok),
    .chr_addr(chr_addr), .chr_cs(chr_cs), .chr_data(chr_data), .chr_ok(chr_ok),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .tout_cnt(tout_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic ok_of(input int who);
    return (who == 0) ? scr_ok : (who == 1) ? obj_ok : chr_ok;
  endfunction

  function automatic logic [DW-1:0] data_of(input int who);
    return (who == 0) ? scr_data : (who == 1) ? obj_data : chr_data;
  endfunction

  task automatic wait_grant(output logic seen);
    int n = 0;
    while (rom_cs !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    seen = (rom_cs === 1'b1);
    checks++;
    if (!seen) begin errors++; $display("FAIL grant_wait rom_cs=%b required 1", rom_cs); end
  endtask

  // Waits for a grant, checks its address, answers after 'delay' cycles, then checks the fill
  task automatic serve(input int who, input logic [AW-1:0] a, input int delay, input logic [DW-1:0] d);
    logic seen;
    exp_t e;
    wait_grant(seen);
    if (!seen) return;
    checks++;
    if (rom_addr !== a) begin errors++; $display("FAIL grant_addr rom_addr=%h required %h", rom_addr, a); end
    repeat (delay) @(negedge clk);
    rom_data = d;
    rom_ok   = 1'b1;
    sbq.push_back('{who, d});
    @(negedge clk);
    rom_ok = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (ok_of(e.who) !== 1'b1 || data_of(e.who) !== e.data)
      begin errors++; $display("FAIL fill_req%0d ok=%b data=%h required ok=1 data=%h", e.who, ok_of(e.who), data_of(e.who), e.data); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rom_cs !== 1'b0 || rom_addr !== '0 || tout_cnt !== 8'd0)
      begin errors++; $display("FAIL reset_rom rom_cs=%b rom_addr=%h tout=%0d required 0 0 0", rom_cs, rom_addr, tout_cnt); end
    checks++;
    if ({scr_ok, obj_ok, chr_ok} !== 3'b000 || scr_data !== '0 || obj_data !== '0 || chr_data !== '0)
      begin errors++; $display("FAIL reset_out ok=%b%b%b data=%h/%h/%h required all 0", scr_ok, obj_ok, chr_ok, scr_data, obj_data, chr_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scroll_fill_hit;
    int bad = 0;
    scr_addr = 17'h1A2B3;
    scr_cs   = 1'b1;
    serve(0, 17'h1A2B3, 2, 32'hDEADBEEF);
    scr_cs = 1'b0;
    repeat (3) @(negedge clk);
    scr_cs = 1'b1;
    #1;
    checks++;
    if (scr_ok !== 1'b1 || scr_data !== 32'hDEADBEEF)
      begin errors++; $display("FAIL scr_hit ok=%b data=%h required 1 DEADBEEF", scr_ok, scr_data); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rom_cs !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL scr_hit_norom rom_cs_high_cycles=%0d required 0", bad); end
    scr_cs = 1'b0;
  endtask

  task automatic test_round_robin;
    obj_addr = 17'h00A01; chr_addr = 17'h00B01;
    obj_cs = 1'b1; chr_cs = 1'b1;
    serve(1, 17'h00A01, 1, 32'hA0A0_0001);
    // scroll raised while obj/chr both pend: it goes first, then chr keeps its turn
    obj_addr = 17'h00A02;
    scr_addr = 17'h05555; scr_cs = 1'b1;
    serve(0, 17'h05555, 1, 32'h5C5C_0001);
    serve(2, 17'h00B01, 1, 32'hB0B0_0001);
    chr_addr = 17'h00B02;
    serve(1, 17'h00A02, 3, 32'hA0A0_0002);
    obj_addr = 17'h00A03;
    serve(2, 17'h00B02, 1, 32'hB0B0_0002);
    serve(1, 17'h00A03, 1, 32'hA0A0_0003);
    obj_cs = 1'b0; chr_cs = 1'b0; scr_cs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stale_ok;
    logic seen;
    exp_t e;
    rom_ok = 1'b1; rom_data = 32'h1111_1111;
    obj_addr = 17'h00100; obj_cs = 1'b1;
    wait_grant(seen);
    if (seen) begin
      @(negedge clk);
      checks++;
      if (rom_cs !== 1'b1 || obj_ok !== 1'b0)
        begin errors++; $display("FAIL stale_ok rom_cs=%b obj_ok=%b required 1 0", rom_cs, obj_ok); end
      rom_data = 32'h2222_2222;
      sbq.push_back('{1, 32'h2222_2222});
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (ok_of(e.who) !== 1'b1 || data_of(e.who) !== e.data)
        begin errors++; $display("FAIL stale_fill ok=%b data=%h required 1 %h", ok_of(e.who), data_of(e.who), e.data); end
    end
    rom_ok = 1'b0;
    obj_cs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort;
    logic seen;
    obj_addr = 17'h00200; obj_cs = 1'b1;
    wait_grant(seen);
    obj_addr = 17'h00300;
    @(negedge clk);
    checks++;
    if (rom_cs !== 1'b0 || obj_ok !== 1'b0 || obj_data !== 32'h2222_2222)
      begin errors++; $display("FAIL abort rom_cs=%b obj_ok=%b obj_data=%h required 0 0 22222222", rom_cs, obj_ok, obj_data); end
    serve(1, 17'h00300, 2, 32'h3333_3333);
    obj_cs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout;
    logic seen;
    int n = 0;
    chr_addr = 17'h1F000; chr_cs = 1'b1;
    wait_grant(seen);
    while (rom_cs === 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n != 256 || tout_cnt !== 8'd1 || chr_ok !== 1'b0)
      begin errors++; $display("FAIL timeout_first wait_cycles=%0d tout=%0d chr_ok=%b required 256 1 0", n, tout_cnt, chr_ok); end
    n = 0;
    while (tout_cnt !== 8'd255 && n < 80000) begin @(negedge clk); n++; end
    checks++;
    if (tout_cnt !== 8'd255) begin errors++; $display("FAIL timeout_reach tout=%0d required 255", tout_cnt); end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (rom_cs !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      while (rom_cs === 1'b1 && n < 400) begin @(negedge clk); n++; end
    end
    checks++;
    if (tout_cnt !== 8'd255) begin errors++; $display("FAIL timeout_sat tout=%0d required 255", tout_cnt); end
    chr_cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_wait;
    logic seen;
    obj_addr = 17'h00300; obj_cs = 1'b1;
    #1;
    checks++;
    if (obj_ok !== 1'b1 || obj_data !== 32'h3333_3333)
      begin errors++; $display("FAIL prehit obj_ok=%b data=%h required 1 33333333", obj_ok, obj_data); end
    scr_addr = 17'h0ABCD; scr_cs = 1'b1;
    wait_grant(seen);
    @(negedge clk);
    rom_data = 32'hBAD0_BAD0; rom_ok = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (rom_cs !== 1'b0 || {scr_ok, obj_ok, chr_ok} !== 3'b000 || scr_data !== '0 || obj_data !== '0 || tout_cnt !== 8'd0)
      begin errors++; $display("FAIL reset_wait rom_cs=%b ok=%b%b%b scr_data=%h obj_data=%h tout=%0d required all 0", rom_cs, scr_ok, obj_ok, chr_ok, scr_data, obj_data, tout_cnt); end
    rom_ok = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_idle rom_cs=%b required 0", rom_cs); end
  endtask

  initial begin
    rst_n = 1'b0;
    scr_addr = '0; obj_addr = '0; chr_addr = '0;
    scr_cs = 1'b0; obj_cs = 1'b0; chr_cs = 1'b0;
    rom_data = '0; rom_ok = 1'b0;
    @(negedge clk);
    test_reset;
    test_scroll_fill_hit;
    test_round_robin;
    test_stale_ok;
    test_abort;
    test_timeout;
    test_reset_mid_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
